// File: rtl/dec_param_scan.sv
// One-hot LED decoder with a direct-select mode and three timed scan modes
// (up, down, bounce) driven by an enable-gated step divider.
module dec_param_scan #(
  parameter int SEL_W    = 4,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      SW,
  output logic [2**SEL_W-1:0]   LED,
  output logic [SEL_W-1:0]      pos,
  output logic                  tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0]       IDX_MAX = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0]       IDX_ONE = SEL_W'(1);
  localparam logic [2**SEL_W-1:0]    LED_ONE = (2**SEL_W)'(1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DN     = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             active_q, active_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_in_s;
  logic             entry_s;
  logic             tick_s;

  assign mode_in_s = mode_e'(mode);

  always_comb begin
    idx_d    = idx_q;
    dir_d    = dir_q;
    active_d = active_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    tick_s   = 1'b0;
    entry_s  = en && (!active_q || (mode_in_s != mode_q));
    if (en) begin
      active_d = 1'b1;
      mode_d   = mode_in_s;
      if (mode_in_s == MODE_DIRECT) begin
        idx_d = SW;
        cnt_d = '0;
      end else if (entry_s) begin
        // Fresh scan starts at SW; the first step waits a full divider period.
        idx_d = SW;
        cnt_d = '0;
        dir_d = (mode_in_s != MODE_DN);
      end else begin
        tick_s = (cnt_q == CNT_MAX);
        cnt_d  = tick_s ? '0 : cnt_q + CNT_W'(1);
        if (tick_s) begin
          case (mode_in_s)
            MODE_UP: idx_d = idx_q + IDX_ONE;
            MODE_DN: idx_d = idx_q - IDX_ONE;
            MODE_BOUNCE: begin
              if (dir_q && (idx_q == IDX_MAX)) begin
                idx_d = idx_q - IDX_ONE;
                dir_d = 1'b0;
              end else if (!dir_q && (idx_q == '0)) begin
                idx_d = idx_q + IDX_ONE;
                dir_d = 1'b1;
              end else begin
                idx_d = dir_q ? (idx_q + IDX_ONE) : (idx_q - IDX_ONE);
              end
            end
            default: idx_d = idx_q;
          endcase
        end else begin
          idx_d = idx_q;
        end
      end
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      dir_q    <= 1'b1;
      active_q <= 1'b0;
      mode_q   <= MODE_DIRECT;
      cnt_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
    end
  end

  // LED stays blank until the first enabled edge; it never looks at SW directly.
  assign LED  = active_q ? (LED_ONE << idx_q) : '0;
  assign pos  = idx_q;
  assign tick = tick_s;

endmodule
